// File: rtl/ram_port_arbiter_if.sv
// Requester-side command port for ram_port_arbiter: one command in flight,
// held until a single-cycle ack.
interface ram_port_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM
// (async read, sync write); one registered access per granted command.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no access in flight; grant on req, rr pointer breaks ties
// S_ACC_A | RAM access cycle for A's latched command; ack A at close
// S_ACC_B | RAM access cycle for B's latched command; ack B at close
module ram_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  ram_port_arbiter_if.slave i_a,
  ram_port_arbiter_if.slave i_b,
  output logic              o_ram_we,
  output logic [AW-1:0]     o_ram_addr,
  output logic [DW-1:0]     o_ram_di,
  input  logic [DW-1:0]     i_ram_do
);

  typedef enum logic [1:0] {S_IDLE, S_ACC_A, S_ACC_B} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant_a;
  logic          w_grant_b;
  logic          r_rr_b;
  logic          r_cmd_we;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_wdata;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  // Closing an access only looks at the other requester, so a requester
  // still holding req while it sees its ack cannot win twice in a row.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_a.req && (!i_b.req || !r_rr_b)) w_grant_a = 1'b1;
        else if (i_b.req)                     w_grant_b = 1'b1;
      end
      S_ACC_A: w_grant_b = i_b.req;
      S_ACC_B: w_grant_a = i_a.req;
      default: ;
    endcase
    w_state_nxt = S_IDLE;
    if (w_grant_a)      w_state_nxt = S_ACC_A;
    else if (w_grant_b) w_state_nxt = S_ACC_B;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_rr_b      <= 1'b0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      if (r_state == S_ACC_A) begin
        r_a_ack <= 1'b1;
        r_rr_b  <= 1'b1;
        if (!r_cmd_we) r_a_rdata <= i_ram_do;
      end
      if (r_state == S_ACC_B) begin
        r_b_ack <= 1'b1;
        r_rr_b  <= 1'b0;
        if (!r_cmd_we) r_b_rdata <= i_ram_do;
      end
      if (w_grant_a) begin
        r_cmd_we    <= i_a.we;
        r_cmd_addr  <= i_a.addr;
        r_cmd_wdata <= i_a.wdata;
      end else if (w_grant_b) begin
        r_cmd_we    <= i_b.we;
        r_cmd_addr  <= i_b.addr;
        r_cmd_wdata <= i_b.wdata;
      end
    end
  end

  // Gated by state so reset kills an in-flight write without waiting for a clock.
  assign o_ram_we   = r_cmd_we & (r_state != S_IDLE);
  assign o_ram_addr = r_cmd_addr;
  assign o_ram_di   = r_cmd_wdata;

  assign i_a.ack   = r_a_ack;
  assign i_a.rdata = r_a_rdata;
  assign i_b.ack   = r_b_ack;
  assign i_b.rdata = r_b_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64x16 RAM:
// serial command table plus contention, fairness and mid-access reset sequences.
module tb_ram_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] mem [64];

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_a        (a_if),
    .i_b        (b_if),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_di   (ram_di),
    .i_ram_do   (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_di;
  assign ram_do = mem[ram_addr];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;

  typedef struct {
    bit            is_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit is_b, input bit req, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (is_b) begin
      b_if.req = req; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata;
    end else begin
      a_if.req = req; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which ack rose.
  task automatic do_cmd(input bit is_b, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp);
    int cycles = 0;
    bit got = 0, other = 0;
    int we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    logic [DW-1:0] we_di = '0;
    logic [DW-1:0] rd;
    drive(is_b, 1'b1, we, addr, wdata);
    while (!got && cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
      if (ram_we) begin we_cnt++; we_addr = ram_addr; we_di = ram_di; end
      if (is_b ? b_if.ack : a_if.ack) got = 1;
      if (is_b ? a_if.ack : b_if.ack) other = 1;
    end
    drive(is_b, 1'b0, 1'b0, '0, '0);
    rd = is_b ? b_if.rdata : a_if.rdata;
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(cycles), 32'd2);
    chk("other_ack", 32'(other), 32'd0);
    if (we) begin
      chk("we_cycles", 32'(we_cnt), 32'd1);
      chk("we_addr", 32'(we_addr), 32'(addr));
      chk("we_data", 32'(we_di), 32'(wdata));
      chk("rdata_hold", 32'(rd), 32'(is_b ? last_b : last_a));
    end else begin
      chk("we_on_read", 32'(we_cnt), 32'd0);
      chk("rdata", 32'(rd), 32'(exp));
      if (is_b) last_b = exp; else last_a = exp;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    int a_k, b_k, order_err, overlap, cyc;
    bit next_b;

    vecs[0]  = '{1'b0, 1'b1, 6'h05, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 6'h05, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b1, 1'b1, 6'h3F, 16'h1234, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 6'h3F, 16'h0000, 16'h1234};
    vecs[4]  = '{1'b1, 1'b1, 6'h00, 16'h5A5A, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 16'h5A5A};
    vecs[6]  = '{1'b0, 1'b1, 6'h0A, 16'h5555, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 6'h0A, 16'h0000, 16'h5555};
    vecs[8]  = '{1'b0, 1'b1, 6'h3F, 16'h0F0F, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 6'h3F, 16'h0000, 16'h0F0F};
    vecs[10] = '{1'b1, 1'b0, 6'h05, 16'h0000, 16'hBEEF};
    vecs[11] = '{1'b0, 1'b1, 6'h20, 16'hC3C3, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 6'h0A, 16'h0000, 16'h5555};
    vecs[13] = '{1'b0, 1'b0, 6'h20, 16'h0000, 16'hC3C3};

    // Reset held with both requesting writes; A must win after release.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 6'h05, 16'h1111);
    drive(1'b1, 1'b1, 1'b1, 6'h06, 16'h2222);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_acks", 32'({a_if.ack, b_if.ack}), 32'd0);
      chk("rst_rdata", 32'({a_if.rdata, b_if.rdata}), 32'd0);
      chk("rst_ram_addr_di", 32'({ram_addr, ram_di}), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("first_grant_addr", 32'({ram_we, ram_addr}), 32'({1'b1, 6'h05}));
      chk("first_a_ack", 32'(a_if.ack), 32'(c == 2));
      chk("first_b_ack", 32'(b_if.ack), 32'(c == 3));
      if (c == 2) drive(1'b0, 1'b0, 1'b0, '0, '0);
      if (c == 3) drive(1'b1, 1'b0, 1'b0, '0, '0);
    end
    chk("first_mem05", 32'(mem[5]), 32'h1111);
    chk("first_mem06", 32'(mem[6]), 32'h2222);

    for (int i = 0; i < 14; i++)
      do_cmd(vecs[i].is_b, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Contention from a fresh reset: A then B back-to-back.
    pulse_reset();
    drive(1'b0, 1'b1, 1'b0, 6'h05, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 6'h3F, 16'h0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk("cont_a_ack", 32'(a_if.ack), 32'(c == 2));
      chk("cont_b_ack", 32'(b_if.ack), 32'(c == 3));
      if (c == 2) begin
        chk("cont_a_rdata", 32'(a_if.rdata), 32'hBEEF);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (c == 3) begin
        chk("cont_b_rdata", 32'(b_if.rdata), 32'h0F0F);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end
    last_a = 16'hBEEF;
    last_b = 16'h0F0F;

    // Fairness: both held for 8 writes each; acks must strictly alternate.
    a_k = 0; b_k = 0; order_err = 0; overlap = 0; cyc = 0; next_b = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 6'(0), 16'hA000);
    drive(1'b1, 1'b1, 1'b1, 6'(32), 16'hB000);
    while ((a_k < 8 || b_k < 8) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (a_if.ack && b_if.ack) overlap++;
      if (a_if.ack) begin
        if (next_b) order_err++;
        next_b = 1'b1;
        a_k++;
        if (a_k < 8) drive(1'b0, 1'b1, 1'b1, 6'(a_k), 16'hA000 + 16'(a_k));
        else drive(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (b_if.ack) begin
        if (!next_b) order_err++;
        next_b = 1'b0;
        b_k++;
        if (b_k < 8) drive(1'b1, 1'b1, 1'b1, 6'(32 + b_k), 16'hB000 + 16'(b_k));
        else drive(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("fair_a_count", 32'(a_k), 32'd8);
    chk("fair_b_count", 32'(b_k), 32'd8);
    chk("fair_order", 32'(order_err), 32'd0);
    chk("fair_overlap", 32'(overlap), 32'd0);
    chk("fair_cycles", 32'(cyc), 32'd17);
    chk("fair_a_rdata_hold", 32'(a_if.rdata), 32'hBEEF);
    for (int k = 0; k < 8; k++) begin
      chk("fair_mem_a", 32'(mem[k]), 32'(16'hA000 + 16'(k)));
      chk("fair_mem_b", 32'(mem[32 + k]), 32'(16'hB000 + 16'(k)));
    end

    // Reset in the middle of A's write of 0xAAAA to address 10.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 6'd10, 16'hAAAA);
    @(posedge clk); #1;
    chk("midrst_we_before", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we_async", 32'(ram_we), 32'd0);
    chk("midrst_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    chk("midrst_no_ack", 32'(a_if.ack), 32'd0);
    chk("midrst_mem", 32'(mem[10]), 32'h5555);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    last_a = '0;
    last_b = '0;
    @(posedge clk); #1;
    chk("midrst_no_ack_after", 32'(a_if.ack), 32'd0);
    do_cmd(1'b0, 1'b0, 6'd10, 16'h0, 16'h5555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
